// File: rtl/mfilter_correlator_pkg.sv
// Package for the matched-filter correlator. It holds the tap count, the sel base
// value, the data/accumulator/threshold widths, the FSM state encoding, and helper
// functions for sign extension and magnitude.
package mfilter_correlator_pkg;

  localparam int DATA_W      = 8;
  localparam int ACC_W       = 18;
  localparam int THRESH_W    = 17;
  localparam int PROD_W      = 2 * DATA_W;
  localparam int MF_NUM_TAPS = 6;

  localparam logic [2:0] MF_SEL_BASE = 3'd2;
  localparam logic [2:0] MF_LAST_IDX = 3'(MF_NUM_TAPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mf_state_e;

  // Sign-extend a sample or coefficient to product width. The low PROD_W bits of
  // a PROD_W x PROD_W multiply then give the exact signed 8x8 product.
  function automatic logic signed [PROD_W-1:0] sext_data(input logic [DATA_W-1:0] d);
    return {{(PROD_W-DATA_W){d[DATA_W-1]}}, d};
  endfunction

  // Sign-extend a 16-bit product to accumulator width before it is added.
  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

  // Absolute value of the accumulator. The result range is -97536..+98304, so
  // negating it cannot overflow.
  function automatic logic [ACC_W-1:0] acc_mag(input logic signed [ACC_W-1:0] v);
    logic [ACC_W-1:0] t;
    t = v;
    if (t[ACC_W-1]) begin
      t = ~t + ACC_W'(1);
    end else begin
      t = v;
    end
    return t;
  endfunction

endpackage

// File: rtl/mfilter_correlator_if.sv
// This interface groups the correlator's bus signals.
//   slave  : the correlator. It drives sel, busy and the result fields. It takes in
//            the strobe, tap data, coefficient write port and threshold.
//   master : the environment, meaning the shift register, the CPU write port and
//            the detect logic.
interface mfilter_correlator_if;
  import mfilter_correlator_pkg::*;

  logic                       rxstrobe;
  logic [2:0]                 sel;
  logic [DATA_W-1:0]          data;
  logic                       coeff_we;
  logic [2:0]                 coeff_addr;
  logic [DATA_W-1:0]          coeff_data;
  logic [THRESH_W-1:0]        threshold;
  logic                       busy;
  logic signed [ACC_W-1:0]    corr_out;
  logic                       corr_valid;
  logic                       match;
  logic [7:0]                 overruns;

  modport master (
    output rxstrobe, data, coeff_we, coeff_addr, coeff_data, threshold,
    input  sel, busy, corr_out, corr_valid, match, overruns
  );

  modport slave (
    input  rxstrobe, data, coeff_we, coeff_addr, coeff_data, threshold,
    output sel, busy, corr_out, corr_valid, match, overruns
  );

endinterface

// File: rtl/mfilter_coeff_bank.sv
// This module is a 6 x DATA_W coefficient register file.
// It has one synchronous write port and one asynchronous read port.
//   clk, reset : clock and asynchronous active-high reset (reset clears all coefficients)
//   we_i       : write strobe. The caller gates it so writes only happen when idle.
//   waddr_i    : write index 0..5. Indexes 6 and 7 are ignored.
//   wdata_i    : signed coefficient to write
//   raddr_i    : read index 0..5. Indexes 6 and 7 read as zero.
//   rdata_o    : coefficient at raddr_i, read combinationally
module mfilter_coeff_bank
  import mfilter_correlator_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [2:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [2:0]        raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] coeff_q [MF_NUM_TAPS];

  // Coefficient storage: each entry is written only when its index is addressed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MF_NUM_TAPS; i++) begin
        coeff_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < MF_NUM_TAPS; i++) begin
        if (we_i && (waddr_i == 3'(i))) begin
          coeff_q[i] <= wdata_i;
        end else begin
          coeff_q[i] <= coeff_q[i];
        end
      end
    end
  end

  // Asynchronous read mux. Out-of-range indexes return zero.
  always_comb begin
    rdata_o = {DATA_W{1'b0}};
    case (raddr_i)
      3'd0:    rdata_o = coeff_q[0];
      3'd1:    rdata_o = coeff_q[1];
      3'd2:    rdata_o = coeff_q[2];
      3'd3:    rdata_o = coeff_q[3];
      3'd4:    rdata_o = coeff_q[4];
      3'd5:    rdata_o = coeff_q[5];
      default: rdata_o = {DATA_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/mfilter_correlator.sv
// This module is a matched-filter correlator. On each rxstrobe it walks the 6 shift
// register taps through sel/data, one per clock. It multiply-accumulates each tap
// against a programmable coefficient. It then publishes one signed correlation plus
// a match flag (|corr| >= threshold).
//   clk, reset  : clock and asynchronous active-high reset
//   bus (slave) : rxstrobe, sel/data tap port, coefficient write port, threshold,
//                 busy, corr_out, corr_valid, match, overruns
// Timing: a strobe sampled at edge k reads taps in cycles k+1..k+6. corr_valid is
// high in cycle k+8.
module mfilter_correlator
  import mfilter_correlator_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  mfilter_correlator_if.slave  bus
);

  mf_state_e               state_q;
  logic [2:0]              idx_q;
  logic [2:0]              sel_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] corr_q;
  logic                    valid_q;
  logic                    match_q;
  logic                    busy_q;
  logic [7:0]              overruns_q;

  logic [DATA_W-1:0]       coeff_rd_s;
  logic                    coeff_wr_s;
  logic signed [PROD_W-1:0] prod_d;
  logic signed [ACC_W-1:0] acc_sum_d;
  logic [ACC_W-1:0]        mag_d;
  logic                    match_d;
  logic [7:0]              overruns_d;

  // Coefficients can only change while idle, so they stay stable within a sequence.
  assign coeff_wr_s = bus.coeff_we & ~busy_q;

  mfilter_coeff_bank u_coeff_bank (
    .clk     (clk),
    .reset   (reset),
    .we_i    (coeff_wr_s),
    .waddr_i (bus.coeff_addr),
    .wdata_i (bus.coeff_data),
    .raddr_i (idx_q),
    .rdata_o (coeff_rd_s)
  );

  // Datapath next-values: tap product, running sum, result magnitude compare, and the
  // saturating overrun increment.
  always_comb begin
    prod_d     = sext_data(bus.data) * sext_data(coeff_rd_s);
    acc_sum_d  = acc_q + sext_prod(prod_d);
    mag_d      = acc_mag(acc_q);
    match_d    = (mag_d >= {{(ACC_W-THRESH_W){1'b0}}, bus.threshold});
    if (overruns_q == 8'hFF) begin
      overruns_d = 8'hFF;
    end else begin
      overruns_d = overruns_q + 8'd1;
    end
  end

  // Sequencer FSM. It has IDLE, then RUN (6 tap clocks), then DONE (publish). All
  // outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= 3'd0;
      sel_q      <= MF_SEL_BASE;
      acc_q      <= {ACC_W{1'b0}};
      corr_q     <= {ACC_W{1'b0}};
      valid_q    <= 1'b0;
      match_q    <= 1'b0;
      busy_q     <= 1'b0;
      overruns_q <= 8'd0;
    end else begin
      valid_q <= 1'b0;
      match_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          idx_q <= 3'd0;
          sel_q <= MF_SEL_BASE;
          acc_q <= {ACC_W{1'b0}};
          if (bus.rxstrobe) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          busy_q <= 1'b1;
          if (bus.rxstrobe) begin
            // The shift register moved under us, so restart from tap 0.
            idx_q      <= 3'd0;
            sel_q      <= MF_SEL_BASE;
            acc_q      <= {ACC_W{1'b0}};
            overruns_q <= overruns_d;
          end else begin
            acc_q <= acc_sum_d;
            if (idx_q == MF_LAST_IDX) begin
              state_q <= ST_DONE;
              idx_q   <= 3'd0;
              sel_q   <= MF_SEL_BASE;
            end else begin
              idx_q <= idx_q + 3'd1;
              sel_q <= idx_q + MF_SEL_BASE + 3'd1;
            end
          end
        end
        ST_DONE: begin
          corr_q  <= acc_q;
          valid_q <= 1'b1;
          match_q <= match_d;
          idx_q   <= 3'd0;
          sel_q   <= MF_SEL_BASE;
          acc_q   <= {ACC_W{1'b0}};
          // A strobe here is not an overrun: the result still publishes, and the
          // new walk starts on the next clock.
          if (bus.rxstrobe) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          idx_q   <= 3'd0;
          sel_q   <= MF_SEL_BASE;
          acc_q   <= {ACC_W{1'b0}};
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel        = sel_q;
  assign bus.busy       = busy_q;
  assign bus.corr_out   = corr_q;
  assign bus.corr_valid = valid_q;
  assign bus.match      = match_q;
  assign bus.overruns   = overruns_q;

endmodule

// File: tb/tb_mfilter_correlator.sv
// Scoreboard bench for mfilter_correlator. A tap array models the shift register
// read port.
module tb_mfilter_correlator;
  import mfilter_correlator_pkg::*;

  logic clk;
  logic reset;
  int   cyc;
  int   n_cmp;
  int   n_err;

  typedef struct {
    int corr;
    int m;
    int at_cyc;
  } exp_t;

  exp_t exp_q[$];
  logic [7:0] taps [6];

  mfilter_correlator_if bus_if ();

  mfilter_correlator dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Shift register read port: combinational tap select.
  always_comb begin
    bus_if.data = 8'd0;
    case (bus_if.sel)
      3'd2:    bus_if.data = taps[0];
      3'd3:    bus_if.data = taps[1];
      3'd4:    bus_if.data = taps[2];
      3'd5:    bus_if.data = taps[3];
      3'd6:    bus_if.data = taps[4];
      3'd7:    bus_if.data = taps[5];
      default: bus_if.data = 8'd0;
    endcase
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Monitor: pop and compare on every corr_valid.
  always @(negedge clk) begin
    if (!reset && bus_if.corr_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: got corr_valid=1 expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("corr_out", int'(bus_if.corr_out), e.corr);
        chk("match", int'(bus_if.match), e.m);
        chk("valid_cycle", cyc, e.at_cyc);
      end
    end
    if (!reset && bus_if.match && !bus_if.corr_valid) begin
      n_cmp++;
      n_err++;
      $display("FAIL match_alone: got match=1 expected 0 without corr_valid (cycle %0d)", cyc);
    end
  end

  // Called at a negedge. Drives one coefficient write for one clock.
  task automatic set_coeff(input int addr, input int val);
    bus_if.coeff_we   = 1'b1;
    bus_if.coeff_addr = 3'(addr);
    bus_if.coeff_data = 8'(val);
    @(negedge clk);
    bus_if.coeff_we = 1'b0;
  endtask

  task automatic set_all_coeffs(input int c0, input int c1, input int c2,
                                input int c3, input int c4, input int c5);
    set_coeff(0, c0); set_coeff(1, c1); set_coeff(2, c2);
    set_coeff(3, c3); set_coeff(4, c4); set_coeff(5, c5);
  endtask

  task automatic set_taps(input int t0, input int t1, input int t2,
                          input int t3, input int t4, input int t5);
    taps[0] = 8'(t0); taps[1] = 8'(t1); taps[2] = 8'(t2);
    taps[3] = 8'(t3); taps[4] = 8'(t4); taps[5] = 8'(t5);
  endtask

  // Called at a negedge. The strobe is sampled at the next edge k, and the result
  // is due at cyc == k+7 (cycle k+8). Returns at the negedge after edge k.
  task automatic strobe(input bit push, input int corr, input int m);
    exp_t e;
    bus_if.rxstrobe = 1'b1;
    if (push) begin
      e.corr = corr; e.m = m; e.at_cyc = cyc + 8;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus_if.rxstrobe = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_pending", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    reset = 1'b1;
    bus_if.rxstrobe = 1'b0; bus_if.coeff_we = 1'b0; bus_if.coeff_addr = 3'd0;
    bus_if.coeff_data = 8'd0; bus_if.threshold = 17'd0;
    set_taps(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_sel", int'(bus_if.sel), 2);
    chk("rst_busy", int'(bus_if.busy), 0);
    chk("rst_corr", int'(bus_if.corr_out), 0);
    chk("rst_valid", int'(bus_if.corr_valid), 0);
    chk("rst_match", int'(bus_if.match), 0);
    chk("rst_overruns", int'(bus_if.overruns), 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: unit coeffs, taps 1..6 -> 21; threshold 22 -> no match; sel walk 2..7.
    set_all_coeffs(1, 1, 1, 1, 1, 1);
    set_taps(1, 2, 3, 4, 5, 6);
    bus_if.threshold = 17'd22;
    strobe(1'b1, 21, 0);
    chk("busy_run", int'(bus_if.busy), 1);
    for (int i = 0; i < 6; i++) begin
      chk("sel_walk", int'(bus_if.sel), 2 + i);
      @(negedge clk);
    end
    drain();
    chk("busy_idle", int'(bus_if.busy), 0);

    // 2: 127 x -128 x 6 = -97536, threshold boundary.
    set_all_coeffs(127, 127, 127, 127, 127, 127);
    set_taps(-128, -128, -128, -128, -128, -128);
    bus_if.threshold = 17'd97536;
    strobe(1'b1, -97536, 1);
    drain();
    bus_if.threshold = 17'd97537;
    strobe(1'b1, -97536, 0);
    drain();

    // 3: alternating coeffs cancel to 0; threshold 0 always matches.
    set_all_coeffs(1, -1, 2, -2, 3, -3);
    bus_if.threshold = 17'd0;
    strobe(1'b1, 0, 1);
    drain();

    // 4: restart 3 clks after the first strobe; taps 1..6 give
    // 1-2+6-8+15-18 = -6.
    set_taps(1, 2, 3, 4, 5, 6);
    strobe(1'b0, 0, 0);
    repeat (2) @(negedge clk);
    strobe(1'b1, -6, 1);
    drain();
    chk("overruns_one", int'(bus_if.overruns), 1);
    bus_if.rxstrobe = 1'b1;
    repeat (300) @(negedge clk);
    begin
      exp_t e;
      e.corr = -6; e.m = 1; e.at_cyc = cyc + 7;
      exp_q.push_back(e);
    end
    bus_if.rxstrobe = 1'b0;
    drain();
    chk("overruns_sat", int'(bus_if.overruns), 255);

    // 5: a write while busy is ignored; the same write when idle applies:
    // 50-2+6-8+15-18 = 43.
    bus_if.threshold = 17'd7;
    strobe(1'b1, -6, 0);
    set_coeff(0, 50);
    drain();
    set_coeff(0, 50);
    strobe(1'b1, 43, 1);
    drain();

    // 6: reset in cycle k+4 aborts the walk with no result.
    strobe(1'b0, 0, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", int'(bus_if.busy), 0);
    chk("mid_rst_corr", int'(bus_if.corr_out), 0);
    chk("mid_rst_valid", int'(bus_if.corr_valid), 0);
    chk("mid_rst_overruns", int'(bus_if.overruns), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    set_all_coeffs(1, 1, 1, 1, 1, 1);
    bus_if.threshold = 17'd21;
    strobe(1'b1, 21, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
